// File: rtl/handshake_delay_if.sv
// Valid/ready bundle for handshake_delay: producer side (in_*), consumer side (out_*) and occupancy.
// master = the environment driving the block, slave = the delay line itself.
interface handshake_delay_if #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 1
);
  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/handshake_delay.sv
// Fixed-latency delay line with valid/ready on both ends; stalls back up only as far
// as the first empty stage, so bubbles collapse and no word is lost or duplicated.
module handshake_delay #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  handshake_delay_if.slave   bus
);
  localparam int CW   = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  localparam int LAST = (CYCLES < 1) ? 0 : CYCLES - 1;
  localparam int NS   = LAST + 1;

  if (CYCLES < 1) begin : g_bad_cycles
    $error("handshake_delay: CYCLES must be >= 1");
  end

  logic [NS-1:0]    v_q, v_d;
  logic [WIDTH-1:0] d_q [NS];
  logic [WIDTH-1:0] d_d [NS];
  logic [NS-1:0]    adv;
  logic [CW-1:0]    count_q, count_d;
  logic             in_xfer, out_xfer;

  // A stage may move when it is empty or the stage ahead of it moves;
  // evaluated from the output end back so out_ready ripples to in_ready.
  always_comb begin
    adv       = '0;
    adv[LAST] = !v_q[LAST] || bus.out_ready;
    for (int i = LAST - 1; i >= 0; i--) begin
      adv[i] = !v_q[i] || adv[i + 1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < NS; i++) begin
      d_d[i] = d_q[i];
    end
    if (adv[0]) begin
      v_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        d_d[0] = bus.in_data;
      end
    end
    // Data of an empty stage is don't-care, so it only changes when a word arrives.
    for (int i = 1; i < NS; i++) begin
      if (adv[i]) begin
        v_d[i] = v_q[i - 1];
        if (v_q[i - 1]) begin
          d_d[i] = d_q[i - 1];
        end
      end
    end
  end

  always_comb begin
    in_xfer  = bus.in_valid && adv[0];
    out_xfer = v_q[LAST] && bus.out_ready;
    count_d  = count_q;
    if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < NS; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < NS; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v_q[LAST];
  assign bus.out_data  = d_q[LAST];
  assign bus.count     = count_q;
endmodule

// File: tb/tb_handshake_delay.sv
// Bench for handshake_delay: a CYCLES=3 and a CYCLES=1 instance share one stimulus stream;
// table vectors, directed sequences and a randomized run against a queue-of-positions model.
`timescale 1ns/1ps
module tb_handshake_delay;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv = 1'b0;
  logic       ordy = 1'b1;
  logic [7:0] id = 8'h00;

  always #5 clk = ~clk;

  handshake_delay_if #(.WIDTH(8), .CYCLES(3)) bus3();
  handshake_delay_if #(.WIDTH(8), .CYCLES(1)) bus1();

  assign bus3.in_valid  = iv;
  assign bus3.in_data   = id;
  assign bus3.out_ready = ordy;
  assign bus1.in_valid  = iv;
  assign bus1.in_data   = id;
  assign bus1.out_ready = ordy;

  handshake_delay #(.WIDTH(8), .CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  handshake_delay #(.WIDTH(8), .CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are sampled 1ns later.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit o);
    @(negedge clk);
    rst  = r;
    iv   = v;
    id   = d;
    ordy = o;
    #1;
  endtask

  typedef struct {
    bit         r;
    bit         v;
    logic [7:0] d;
    bit         o;
    bit         chk;
    bit         e_ir;
    bit         e_ov;
    bit         chk_d;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, logic [7:0] d, bit o, bit chk, bit e_ir,
                              bit e_ov, bit chk_d, logic [7:0] e_od, logic [1:0] e_cnt);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.o = o; x.chk = chk; x.e_ir = e_ir;
    x.e_ov = e_ov; x.chk_d = chk_d; x.e_od = e_od; x.e_cnt = e_cnt;
    return x;
  endfunction

  // Model: in-flight words in acceptance order, each with the stage index it occupies.
  typedef struct {
    logic [7:0] d;
    int         pos;
  } item_t;
  typedef item_t itemq_t[$];

  function automatic bit m_ir(itemq_t q, int c, bit o);
    return (q.size() < c) || o;
  endfunction

  function automatic bit m_ov(itemq_t q, int c);
    return (q.size() > 0) && (q[0].pos == c - 1);
  endfunction

  function automatic itemq_t m_step(itemq_t q, int c, bit r, bit v, logic [7:0] d, bit o);
    itemq_t n;
    bit     acc;
    if (r) return n;
    acc = v && m_ir(q, c, o);
    n = q;
    if (m_ov(n, c) && o) void'(n.pop_front());
    for (int i = 0; i < n.size(); i++) begin
      int lim;
      lim = (i == 0) ? c : n[i - 1].pos;
      if (n[i].pos + 1 < lim) n[i].pos = n[i].pos + 1;
    end
    if (acc) begin
      item_t it;
      it.d   = d;
      it.pos = 0;
      n.push_back(it);
    end
    return n;
  endfunction

  vec_t   vecs[9];
  itemq_t m3, m1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    int         acc;

    // Reset, then single-word latency with a two-cycle stall on presentation.
    vecs[0] = mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 2'd0);
    vecs[1] = mk(1, 0, 8'h00, 1, 1, 1, 0, 1, 8'h00, 2'd0);
    vecs[2] = mk(0, 1, 8'hA5, 1, 1, 1, 0, 1, 8'h00, 2'd0);
    vecs[3] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 2'd1);
    vecs[4] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 2'd1);
    vecs[5] = mk(0, 0, 8'h00, 0, 1, 1, 1, 1, 8'hA5, 2'd1);
    vecs[6] = mk(0, 0, 8'h00, 0, 1, 1, 1, 1, 8'hA5, 2'd1);
    vecs[7] = mk(0, 0, 8'h00, 1, 1, 1, 1, 1, 8'hA5, 2'd1);
    vecs[8] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 2'd0);

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].o);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_in_ready", i), 32'(bus3.in_ready), 32'(vecs[i].e_ir));
        check($sformatf("vec%0d_out_valid", i), 32'(bus3.out_valid), 32'(vecs[i].e_ov));
        check($sformatf("vec%0d_count", i), 32'(bus3.count), 32'(vecs[i].e_cnt));
        if (vecs[i].chk_d)
          check($sformatf("vec%0d_out_data", i), 32'(bus3.out_data), 32'(vecs[i].e_od));
      end
      $display("vec %0d: rst=%0d in_valid=%0d in_data=%02h out_ready=%0d -> in_ready=%0d out_valid=%0d out_data=%02h count=%0d",
               i, vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].o,
               bus3.in_ready, bus3.out_valid, bus3.out_data, bus3.count);
    end

    // Streaming 0..15 at full rate.
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    for (int k = 0; k < 19; k++) begin
      cycle(0, k < 16, 8'(k), 1);
      check("stream_in_ready", 32'(bus3.in_ready), 32'd1);
      if (k >= 3) begin
        check("stream_out_valid", 32'(bus3.out_valid), 32'd1);
        check("stream_out_data", 32'(bus3.out_data), 32'(k - 3));
        $display("stream: out_data=%02h", bus3.out_data);
      end else begin
        check("stream_out_valid_early", 32'(bus3.out_valid), 32'd0);
      end
    end

    // Fill with out_ready low, then stream through a full pipe.
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    w   = 8'h10;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, w, 0);
      if (bus3.in_ready) begin
        acc++;
        w = w + 8'd1;
      end
    end
    check("full_accepted", 32'(acc), 32'd3);
    cycle(0, 1, w, 0);
    check("full_count", 32'(bus3.count), 32'd3);
    check("full_in_ready", 32'(bus3.in_ready), 32'd0);
    check("full_out_data", 32'(bus3.out_data), 32'h10);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, w, 1);
      check("thru_in_ready", 32'(bus3.in_ready), 32'd1);
      check("thru_out_valid", 32'(bus3.out_valid), 32'd1);
      check("thru_out_data", 32'(bus3.out_data), 32'(8'h10 + k));
      check("thru_count", 32'(bus3.count), 32'd3);
      $display("full-thru: in=%02h out=%02h count=%0d", w, bus3.out_data, bus3.count);
      w = w + 8'd1;
    end

    // Mid-operation reset with an input offered during reset.
    cycle(1, 0, 8'h00, 1);
    cycle(0, 1, 8'hC0, 0);
    cycle(0, 1, 8'hC1, 0);
    cycle(0, 1, 8'hC2, 0);
    check("preflush_count", 32'(bus3.count), 32'd2);
    cycle(1, 1, 8'hEE, 0);
    cycle(0, 0, 8'h00, 1);
    check("flush_count", 32'(bus3.count), 32'd0);
    check("flush_out_valid", 32'(bus3.out_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 8'h00, 1);
      check("flush_stays_empty", 32'(bus3.out_valid), 32'd0);
    end

    // CYCLES=1 latency and full behaviour.
    cycle(1, 0, 8'h00, 1);
    cycle(0, 1, 8'h5A, 1);
    check("c1_in_ready", 32'(bus1.in_ready), 32'd1);
    check("c1_out_valid0", 32'(bus1.out_valid), 32'd0);
    cycle(0, 0, 8'h00, 1);
    check("c1_out_valid1", 32'(bus1.out_valid), 32'd1);
    check("c1_out_data", 32'(bus1.out_data), 32'h5A);
    check("c1_count1", 32'(bus1.count), 32'd1);
    cycle(0, 1, 8'h77, 0);
    check("c1_count0", 32'(bus1.count), 32'd0);
    cycle(0, 1, 8'h88, 0);
    check("c1_full_in_ready", 32'(bus1.in_ready), 32'd0);
    check("c1_full_data", 32'(bus1.out_data), 32'h77);
    cycle(0, 1, 8'h88, 1);
    check("c1_pass_in_ready", 32'(bus1.in_ready), 32'd1);
    check("c1_pass_data0", 32'(bus1.out_data), 32'h77);
    cycle(0, 0, 8'h00, 1);
    check("c1_pass_data1", 32'(bus1.out_data), 32'h88);

    // Randomized traffic against the model, both instances at once.
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    m3 = {};
    m1 = {};
    for (int k = 0; k < 1000; k++) begin
      bit         v, o;
      logic [7:0] d;
      v = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      cycle(0, v, d, o);
      check("rnd3_in_ready", 32'(bus3.in_ready), 32'(m_ir(m3, 3, o)));
      check("rnd3_out_valid", 32'(bus3.out_valid), 32'(m_ov(m3, 3)));
      check("rnd3_count", 32'(bus3.count), 32'(m3.size()));
      if (m_ov(m3, 3)) begin
        check("rnd3_out_data", 32'(bus3.out_data), 32'(m3[0].d));
        if (o) $display("rnd %0d: out %02h count=%0d", k, bus3.out_data, bus3.count);
      end
      check("rnd1_in_ready", 32'(bus1.in_ready), 32'(m_ir(m1, 1, o)));
      check("rnd1_out_valid", 32'(bus1.out_valid), 32'(m_ov(m1, 1)));
      check("rnd1_count", 32'(bus1.count), 32'(m1.size()));
      if (m_ov(m1, 1))
        check("rnd1_out_data", 32'(bus1.out_data), 32'(m1[0].d));
      m3 = m_step(m3, 3, 1'b0, v, d, o);
      m1 = m_step(m1, 1, 1'b0, v, d, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
